// File: rtl/mult_seq_ctrl_if.sv
// Handshake and multiplier-side signal bundle for mult_seq_ctrl.
// master: the controller's view; slave: the surrounding environment's view.
interface mult_seq_ctrl_if #(
   parameter int unsigned N = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_a;
   logic [N-1:0]   in_b;
   logic           mul_start;
   logic [N-1:0]   mul_ain;
   logic [N-1:0]   mul_bin;
   logic           mul_done;
   logic [2*N-1:0] mul_yout;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] out_y;
   logic           err;

   modport master (
      input  in_valid, in_a, in_b, mul_done, mul_yout, out_ready,
      output in_ready, mul_start, mul_ain, mul_bin, out_valid, out_y, err
   );

   modport slave (
      output in_valid, in_a, in_b, mul_done, mul_yout, out_ready,
      input  in_ready, mul_start, mul_ain, mul_bin, out_valid, out_y, err
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Operand FIFO feeding a sequential multiplier one job at a time, with an in-order result slot.
// Optional WAIT timeout/abort path enabled by defining MULT_SEQ_CTRL_TIMEOUT_EN.
module mult_seq_ctrl #(
   parameter int unsigned N     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            resetb,
   mult_seq_ctrl_if.master bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StAbort} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   fifo_a_q [DEPTH];
   logic [N-1:0]   fifo_b_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic [N-1:0]   ain_q, bin_q;
   logic           out_valid_q, out_valid_d;
   logic [2*N-1:0] out_y_q, out_y_d;
   logic           push, pop, capture, slot_free;

   assign bus.in_ready  = (count_q != CW'(DEPTH));
   assign push          = bus.in_valid && bus.in_ready;
   // Slot may be refilled if the consumer drains it at the same edge.
   assign slot_free     = !out_valid_q || bus.out_ready;
   assign bus.mul_start = (state_q == StIssue);
   assign bus.mul_ain   = ain_q;
   assign bus.mul_bin   = bin_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_y     = out_y_q;

`ifdef MULT_SEQ_CTRL_TIMEOUT_EN
   localparam int unsigned Limit = 2 * N + 2;
   localparam int unsigned TW    = $clog2(Limit + 1);
   logic [TW-1:0] wait_cnt_q;
   logic          err_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (state_q == StIssue) begin
            wait_cnt_q <= '0;
         end else if (state_q == StWait) begin
            wait_cnt_q <= wait_cnt_q + TW'(1);
         end
         if (state_q == StAbort) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0 && slot_free) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (bus.mul_done) begin
               capture = 1'b1;
               state_d = StIdle;
`ifdef MULT_SEQ_CTRL_TIMEOUT_EN
            end else if (wait_cnt_q == TW'(Limit - 1)) begin
               state_d = StAbort;
`endif
            end
         end
         StAbort: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      if (capture) begin
         out_valid_d = 1'b1;
         out_y_d     = bus.mul_yout;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_a_q[wr_ptr_q] <= bus.in_a;
         fifo_b_q[wr_ptr_q] <= bus.in_b;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ain_q       <= '0;
         bin_q       <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            ain_q    <= fifo_a_q[rd_ptr_q];
            bin_q    <= fifo_b_q[rd_ptr_q];
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end
endmodule
